// File: rtl/ws2812_gpio_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_gpio_serializer_if
// Brief    : PIO command word in, WS2812 line and status out.
// Revision : 1.0
// ============================================================================
interface ws2812_gpio_serializer_if;
    logic [31:0] gpio_word;
    logic        pixel_dout;
    logic        busy;
    logic        overflow;
    logic [15:0] pixel_count;

    modport master (
        output gpio_word,
        input  pixel_dout,
        input  busy,
        input  overflow,
        input  pixel_count
    );

    modport slave (
        input  gpio_word,
        output pixel_dout,
        output busy,
        output overflow,
        output pixel_count
    );
endinterface
`default_nettype wire

// File: rtl/ws2812_gpio_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_gpio_serializer
// Brief    : Toggle-strobed PIO commands to WS2812 pixel/latch waveforms,
//            with one pending-command slot for gapless chaining.
// Revision : 1.0
// ============================================================================
module ws2812_gpio_serializer #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int BIT_CYC = 63,
    parameter int RES_CYC = 3000
) (
    input  wire                          clk,
    input  wire                          reset,
    ws2812_gpio_serializer_if.slave      bus
);

    localparam logic [15:0] c_T0H_LAST = 16'(T0H_CYC - 1);
    localparam logic [15:0] c_T1H_LAST = 16'(T1H_CYC - 1);
    localparam logic [15:0] c_T0L_LAST = 16'(BIT_CYC - T0H_CYC - 1);
    localparam logic [15:0] c_T1L_LAST = 16'(BIT_CYC - T1H_CYC - 1);
    localparam logic [15:0] c_RES_LAST = 16'(RES_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] gpio_q;
    logic        prev_toggle_q;
    logic        armed_q;
    logic        pend_valid_q;
    logic        pend_latch_q;
    logic [23:0] pend_pix_q;
    logic [23:0] pix_q;
    logic [4:0]  bit_idx_q;
    logic [15:0] cnt_q;
    logic        dout_q;
    logic        busy_q;
    logic        ovf_q;
    logic [15:0] pcount_q;

    logic        cmd_w;
    logic        cur_bit_w;
    logic [15:0] hi_last_w;
    logic [15:0] lo_last_w;
    logic        idle_w;
    logic        pix_done_w;
    logic        latch_done_w;
    logic        done_w;
    logic        load_pend_w;
    logic        start_cmd_w;
    logic        to_pend_w;
    logic        drop_w;
    logic        start_w;
    logic        start_latch_w;
    logic [23:0] start_pix_w;
    logic        pend_valid_d;
    logic        active_d;

    // Sampled unconditionally so prev_toggle sees the live word when reset drops.
    always_ff @(posedge clk) begin
        gpio_q <= bus.gpio_word;
    end

    always_comb begin
        cmd_w         = armed_q & (gpio_q[31] ^ prev_toggle_q);
        cur_bit_w     = pix_q[bit_idx_q];
        hi_last_w     = cur_bit_w ? c_T1H_LAST : c_T0H_LAST;
        lo_last_w     = cur_bit_w ? c_T1L_LAST : c_T0L_LAST;
        idle_w        = (state_q == S_IDLE);
        pix_done_w    = (state_q == S_LOW) && (cnt_q == lo_last_w) && (bit_idx_q == 5'd0);
        latch_done_w  = (state_q == S_LATCH) && (cnt_q == c_RES_LAST);
        done_w        = pix_done_w | latch_done_w;
        // A slot freed on this edge is reusable by a command arriving on the same edge.
        load_pend_w   = done_w & pend_valid_q;
        start_cmd_w   = cmd_w & ~pend_valid_q & (idle_w | done_w);
        to_pend_w     = cmd_w & ~start_cmd_w & (~pend_valid_q | done_w);
        drop_w        = cmd_w & ~start_cmd_w & ~to_pend_w;
        start_w       = load_pend_w | start_cmd_w;
        start_latch_w = load_pend_w ? pend_latch_q : gpio_q[30];
        start_pix_w   = load_pend_w ? pend_pix_q : gpio_q[23:0];
        pend_valid_d  = to_pend_w | (pend_valid_q & ~load_pend_w);
        active_d      = start_w | (~idle_w & ~done_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            prev_toggle_q <= 1'b0;
            armed_q       <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_latch_q  <= 1'b0;
            pend_pix_q    <= 24'd0;
            pix_q         <= 24'd0;
            bit_idx_q     <= 5'd0;
            cnt_q         <= 16'd0;
            dout_q        <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
            pcount_q      <= 16'd0;
        end else begin
            armed_q       <= 1'b1;
            prev_toggle_q <= gpio_q[31];
            pend_valid_q  <= pend_valid_d;
            busy_q        <= active_d | pend_valid_d;

            if (to_pend_w) begin
                pend_latch_q <= gpio_q[30];
                pend_pix_q   <= gpio_q[23:0];
            end

            if (drop_w) begin
                ovf_q <= 1'b1;
            end else if ((start_cmd_w | to_pend_w) & gpio_q[29]) begin
                ovf_q <= 1'b0;
            end

            if (latch_done_w) begin
                pcount_q <= 16'd0;
            end else if (pix_done_w && (pcount_q != 16'hFFFF)) begin
                pcount_q <= pcount_q + 16'd1;
            end

            if (start_w) begin
                cnt_q <= 16'd0;
                if (start_latch_w) begin
                    state_q <= S_LATCH;
                    dout_q  <= 1'b0;
                end else begin
                    state_q   <= S_HIGH;
                    dout_q    <= 1'b1;
                    pix_q     <= start_pix_w;
                    bit_idx_q <= 5'd23;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        dout_q <= 1'b0;
                    end
                    S_HIGH: begin
                        if (cnt_q == hi_last_w) begin
                            state_q <= S_LOW;
                            cnt_q   <= 16'd0;
                            dout_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    S_LOW: begin
                        if (cnt_q == lo_last_w) begin
                            cnt_q <= 16'd0;
                            if (bit_idx_q == 5'd0) begin
                                state_q <= S_IDLE;
                                dout_q  <= 1'b0;
                            end else begin
                                bit_idx_q <= bit_idx_q - 5'd1;
                                state_q   <= S_HIGH;
                                dout_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    S_LATCH: begin
                        dout_q <= 1'b0;
                        if (cnt_q == c_RES_LAST) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        dout_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pixel_dout  = dout_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;
    assign bus.pixel_count = pcount_q;

endmodule
`default_nettype wire
